multicycle_control_unit: RTL and testbench

Registered, multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the datapath control strobes from the current state and a latched opcode. Memory accesses use a ready handshake with a bounded wait timeout. Opcode width is parametrised; unused opcodes fall back to ADD unless trap support is compiled in.

---
 rtl/multicycle_control_unit_pkg.sv | 50 +++++
 rtl/multicycle_control_unit_if.sv | 45 ++++
 rtl/multicycle_control_unit_mem_wait_timer.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// opcode values, ALU operation codes and the opcode classifier.
package cu_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      ERROR  = 3'd6,
      HALT   = 3'd7
   } state_t;

   localparam int unsigned OP_ADD   = 0;
   localparam int unsigned OP_SUB   = 1;
   localparam int unsigned OP_LOAD  = 2;
   localparam int unsigned OP_STORE = 3;
   localparam int unsigned OP_JUMP  = 4;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   // Instruction class derived from the latched opcode.
   typedef enum logic [2:0] {
      K_ADD,
      K_SUB,
      K_LOAD,
      K_STORE,
      K_JUMP,
      K_ILLEGAL
   } op_kind_t;

   // Classify the low three opcode bits; the caller has already confirmed
   // that any wider opcode bits are zero.
   function automatic op_kind_t classify(input logic [2:0] op3);
      op_kind_t k;
      case (op3)
         3'(OP_ADD):   k = K_ADD;
         3'(OP_SUB):   k = K_SUB;
         3'(OP_LOAD):  k = K_LOAD;
         3'(OP_STORE): k = K_STORE;
         3'(OP_JUMP):  k = K_JUMP;
         default:      k = K_ILLEGAL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. The master side is the control
// unit (drives strobes), the slave side is the datapath and memory.
// Optional macro ILLEGAL_OPCODE_TRAP_EN adds the sticky illegal_op flag.
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 3
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                ir_write;
   logic                pc_write;
   logic                reg_write;
   logic                alu_src;
   logic                mem_to_reg;
   logic                mem_read;
   logic                mem_write;
   logic [1:0]          alu_op;
   logic                jump;
   logic                mem_err;
   logic [2:0]          state_o;
`ifdef ILLEGAL_OPCODE_TRAP_EN
   logic                illegal_op;

   modport master (
      input  opcode, mem_ready,
      output ir_write, pc_write, reg_write, alu_src, mem_to_reg,
             mem_read, mem_write, alu_op, jump, mem_err, state_o, illegal_op
   );
   modport slave (
      output opcode, mem_ready,
      input  ir_write, pc_write, reg_write, alu_src, mem_to_reg,
             mem_read, mem_write, alu_op, jump, mem_err, state_o, illegal_op
   );
`else
   modport master (
      input  opcode, mem_ready,
      output ir_write, pc_write, reg_write, alu_src, mem_to_reg,
             mem_read, mem_write, alu_op, jump, mem_err, state_o
   );
   modport slave (
      output opcode, mem_ready,
      input  ir_write, pc_write, reg_write, alu_src, mem_to_reg,
             mem_read, mem_write, alu_op, jump, mem_err, state_o
   );
`endif
endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Memory wait timer shared by FETCH and MEM. Counts cycles spent waiting
// for mem_ready, saturating at MEM_TIMEOUT, and flags a timeout when the
// limit is reached and the memory is still not ready. MEM_TIMEOUT = 0
// disables the timeout entirely.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic ready,
   output logic timeout
);
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MEM_TIMEOUT);
   localparam bit               LIMIT_EN = (MEM_TIMEOUT != 0);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count unready wait cycles up to the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !ready && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Wait-counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // A ready in the limit cycle suppresses the timeout.
   assign timeout = LIMIT_EN && enable && !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and decodes
// datapath strobes from the registered state and latched opcode. Memory
// waits are bounded by mem_wait_timer; a timeout parks the FSM in ERROR.
// Optional macro ILLEGAL_OPCODE_TRAP_EN: unused opcodes trap to HALT and
// raise illegal_op instead of executing as ADD.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int OPCODE_W    = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_control_unit_if.master bus
);
   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic                mem_err_q, mem_err_d;
`ifdef ILLEGAL_OPCODE_TRAP_EN
   logic                illegal_op_q, illegal_op_d;
`endif

   op_kind_t   kind;
   logic       in_wait;
   logic       tmr_clear;
   logic       tmr_timeout;
   logic       ir_write, pc_write, reg_write, alu_src, mem_to_reg;
   logic       mem_read, mem_write, jump;
   logic [1:0] alu_op;

   // Classify the latched opcode; unused values become ADD unless trapping.
   always_comb begin
      kind = K_ILLEGAL;
      if ((opcode_q >> 3) == '0) kind = classify(opcode_q[2:0]);
`ifndef ILLEGAL_OPCODE_TRAP_EN
      if (kind == K_ILLEGAL) kind = K_ADD;
`endif
   end

   // Leaving FETCH/MEM always coincides with mem_ready, so clearing on
   // ready or outside those states guarantees a zero count on entry.
   assign in_wait   = (state_q == FETCH) || (state_q == MEM);
   assign tmr_clear = !in_wait || bus.mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (in_wait),
      .ready   (bus.mem_ready),
      .timeout (tmr_timeout)
   );

   // Next-state, opcode latch, sticky flags and strobe decode.
   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      mem_err_d  = mem_err_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_op_d = illegal_op_q;
`endif
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = ALU_ADD;
      jump       = 1'b0;

      case (state_q)
         IDLE: state_d = FETCH;

         FETCH: begin
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end else if (tmr_timeout) begin
               state_d   = ERROR;
               mem_err_d = 1'b1;
            end
         end

         DECODE: begin
            opcode_d = bus.opcode;
            state_d  = EXEC;
         end

         EXEC: begin
            case (kind)
               K_ADD: begin
                  alu_op  = ALU_ADD;
                  state_d = WB;
               end
               K_SUB: begin
                  alu_op  = ALU_SUB;
                  state_d = WB;
               end
               K_LOAD, K_STORE: begin
                  alu_src = 1'b1;
                  state_d = MEM;
               end
               K_JUMP: begin
                  jump     = 1'b1;
                  pc_write = 1'b1;
                  state_d  = FETCH;
               end
               default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                  state_d      = HALT;
                  illegal_op_d = 1'b1;
`else
                  state_d = WB;
`endif
               end
            endcase
         end

         MEM: begin
            alu_src = 1'b1;
            if (kind == K_LOAD) mem_read  = 1'b1;
            else                mem_write = 1'b1;
            if (bus.mem_ready) begin
               state_d = (kind == K_LOAD) ? WB : FETCH;
            end else if (tmr_timeout) begin
               state_d   = ERROR;
               mem_err_d = 1'b1;
            end
         end

         WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (kind == K_LOAD);
            alu_src    = (kind == K_LOAD);
            alu_op     = (kind == K_SUB) ? ALU_SUB : ALU_ADD;
            state_d    = FETCH;
         end

         ERROR: state_d = ERROR;
         HALT:  state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // State, latched opcode and sticky flags; reset is asynchronous.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         opcode_q  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         mem_err_q <= mem_err_d;
      end
   end

`ifdef ILLEGAL_OPCODE_TRAP_EN
   // Sticky illegal-opcode flag, set on the edge into HALT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) illegal_op_q <= 1'b0;
      else       illegal_op_q <= illegal_op_d;
   end

   assign bus.illegal_op = illegal_op_q;
`endif

   assign bus.ir_write   = ir_write;
   assign bus.pc_write   = pc_write;
   assign bus.reg_write  = reg_write;
   assign bus.alu_src    = alu_src;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.alu_op     = alu_op;
   assign bus.jump       = jump;
   assign bus.mem_err    = mem_err_q;
   assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. A reference model expands each
// instruction (opcode, fetch wait, memory wait) into the per-cycle state
// and strobes the behaviour rules call for; the DUT is stepped one cycle
// per expected entry. Honours ILLEGAL_OPCODE_TRAP_EN like the design.
module tb_multicycle_control_unit;

   localparam int OW = 3;
   localparam int TO = 15;
   localparam int CW = 4;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                          ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                          ST_ERROR = 3'd6, ST_HALT = 3'd7;

   // Strobe bit positions: ir pc rw as m2r mr mw aop[1:0] j err
   localparam logic [10:0] B_IR  = 11'b100_0000_0000;
   localparam logic [10:0] B_PC  = 11'b010_0000_0000;
   localparam logic [10:0] B_RW  = 11'b001_0000_0000;
   localparam logic [10:0] B_AS  = 11'b000_1000_0000;
   localparam logic [10:0] B_M2R = 11'b000_0100_0000;
   localparam logic [10:0] B_MR  = 11'b000_0010_0000;
   localparam logic [10:0] B_MW  = 11'b000_0001_0000;
   localparam logic [10:0] B_SUB = 11'b000_0000_0100;
   localparam logic [10:0] B_J   = 11'b000_0000_0010;
   localparam logic [10:0] B_ERR = 11'b000_0000_0001;

   typedef struct packed {
      logic [2:0]    st;
      logic          rdy;
      logic [OW-1:0] opc;
      logic [10:0]   outs;
      logic          ill;
   } cyc_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   cyc_t q[$];

   multicycle_control_unit_if #(.OPCODE_W(OW)) bus ();

   multicycle_control_unit #(
      .OPCODE_W    (OW),
      .MEM_TIMEOUT (TO),
      .CNT_W       (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] observe();
      logic ill;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      ill = bus.illegal_op;
`else
      ill = 1'b0;
`endif
      return {bus.state_o, bus.ir_write, bus.pc_write, bus.reg_write, bus.alu_src,
              bus.mem_to_reg, bus.mem_read, bus.mem_write, bus.alu_op, bus.jump,
              bus.mem_err, ill};
   endfunction

   // Instruction class from the opcode rules: 0..4 defined, others ADD or trap.
   function automatic int kind_of(input int op);
      if (op <= 4) return op;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      return 5;
`else
      return 0;
`endif
   endfunction

   function automatic logic [OW-1:0] rnd_op();
      return OW'($urandom);
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom);
   endfunction

   task automatic add(input logic [2:0] st, input logic rdy, input logic [OW-1:0] opc,
                      input logic [10:0] outs, input logic ill);
      cyc_t e;
      e.st = st; e.rdy = rdy; e.opc = opc; e.outs = outs; e.ill = ill;
      q.push_back(e);
   endtask

   // Expand one instruction. fw/mw = wait cycles before mem_ready in FETCH/MEM;
   // a negative value never raises mem_ready there (timeout), after which
   // 'hold' ERROR cycles are expected. Trapped opcodes expect 'hold' HALT cycles.
   task automatic gen_instr(input int op, input int fw, input int mw, input int hold);
      int k;
      logic [10:0] wb;
      k = kind_of(op);
      if (fw < 0) begin
         for (int i = 0; i <= TO; i++) add(ST_FETCH, 1'b0, rnd_op(), B_MR, 1'b0);
         for (int i = 0; i < hold; i++) add(ST_ERROR, rnd_bit(), rnd_op(), B_ERR, 1'b0);
         return;
      end
      for (int i = 0; i <= fw; i++) begin
         if (i == fw) add(ST_FETCH, 1'b1, rnd_op(), B_MR | B_IR | B_PC, 1'b0);
         else         add(ST_FETCH, 1'b0, rnd_op(), B_MR, 1'b0);
      end
      add(ST_DECODE, rnd_bit(), OW'(op), 11'h0, 1'b0);
      case (k)
         0:       add(ST_EXEC, rnd_bit(), rnd_op(), 11'h0, 1'b0);
         1:       add(ST_EXEC, rnd_bit(), rnd_op(), B_SUB, 1'b0);
         2, 3:    add(ST_EXEC, rnd_bit(), rnd_op(), B_AS, 1'b0);
         4:       add(ST_EXEC, rnd_bit(), rnd_op(), B_J | B_PC, 1'b0);
         default: add(ST_EXEC, rnd_bit(), rnd_op(), 11'h0, 1'b0);
      endcase
      if (k == 5) begin
         for (int i = 0; i < hold; i++) add(ST_HALT, rnd_bit(), rnd_op(), 11'h0, 1'b1);
         return;
      end
      if (k == 2 || k == 3) begin
         if (mw < 0) begin
            for (int i = 0; i <= TO; i++)
               add(ST_MEM, 1'b0, rnd_op(), B_AS | ((k == 2) ? B_MR : B_MW), 1'b0);
            for (int i = 0; i < hold; i++) add(ST_ERROR, rnd_bit(), rnd_op(), B_ERR, 1'b0);
            return;
         end
         for (int i = 0; i <= mw; i++)
            add(ST_MEM, (i == mw), rnd_op(), B_AS | ((k == 2) ? B_MR : B_MW), 1'b0);
      end
      if (k == 2) add(ST_WB, rnd_bit(), rnd_op(), B_RW | B_M2R | B_AS, 1'b0);
      if (k == 0 || k == 1) begin
         wb = B_RW | ((k == 1) ? B_SUB : 11'h0);
         add(ST_WB, rnd_bit(), rnd_op(), wb, 1'b0);
      end
   endtask

   // Drive one cycle's inputs just after the edge and sample mid-cycle.
   task automatic apply(input cyc_t e, output logic [14:0] obs);
      bus.mem_ready = e.rdy;
      bus.opcode    = e.opc;
      #4;
      obs = observe();
   endtask

   // Assert reset over two edges and release it just after an edge, so the
   // next cycle window is the IDLE cycle.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      add(ST_IDLE, rnd_bit(), rnd_op(), 11'h0, 1'b0);
   endtask

   task automatic test_reset();
      logic [14:0] obs;
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode = '0;
      #3;
      obs = observe();
      vectors++;
      if (obs !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_idle: got %h want %h", obs, 15'h0);
      end
      @(posedge clk); #1;
      bus.mem_ready = 1'b1;
      #2;
      obs = observe();
      vectors++;
      if (obs !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_held_over_edge: got %h want %h", obs, 15'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      bus.mem_ready = 1'b0;
      #2;
      obs = observe();
      vectors++;
      if (obs !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_release_idle: got %h want %h", obs, 15'h0);
      end
      @(posedge clk); #1;
      #2;
      obs = observe();
      vectors++;
      if (obs !== {ST_FETCH, B_MR, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_then_fetch: got %h want %h", obs, {ST_FETCH, B_MR, 1'b0});
      end
   endtask

   task automatic test_add_sub_jump();
      cyc_t e;
      logic [14:0] obs;
      int n;
      do_reset();
      gen_instr(0, 0, 0, 0);
      gen_instr(1, 1, 0, 0);
      gen_instr(4, 0, 0, 0);
      gen_instr(0, 0, 0, 0);
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL add_sub_jump cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_waits();
      cyc_t e;
      logic [14:0] obs;
      int n;
      do_reset();
      gen_instr(2, 0, 3, 0);
      gen_instr(3, 2, 0, 0);
      gen_instr(0, TO, 0, 0);
      gen_instr(3, 0, TO, 0);
      gen_instr(2, 1, TO, 0);
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL mem_waits cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fetch_timeout();
      cyc_t e;
      logic [14:0] obs;
      int n;
      do_reset();
      gen_instr(0, -1, 0, 6);
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL fetch_timeout cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_timeout();
      cyc_t e;
      logic [14:0] obs;
      int n;
      do_reset();
      gen_instr(1, 0, 0, 0);
      gen_instr(3, 0, -1, 5);
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL mem_timeout cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal_opcode();
      cyc_t e;
      logic [14:0] obs;
      int n;
      do_reset();
      gen_instr(7, 0, 0, 4);
`ifndef ILLEGAL_OPCODE_TRAP_EN
      gen_instr(5, 1, 0, 0);
      gen_instr(6, 0, 0, 0);
      gen_instr(2, 0, 0, 0);
`endif
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL illegal_opcode cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t e;
      logic [14:0] obs;
      int n, op, fw, mw, maxop;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      maxop = 4;
`else
      maxop = 7;
`endif
      do_reset();
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(maxop, 0);
         fw = ($urandom_range(7, 0) == 0) ? $urandom_range(TO, 0) : $urandom_range(2, 0);
         mw = ($urandom_range(7, 0) == 0) ? $urandom_range(TO, 0) : $urandom_range(2, 0);
         gen_instr(op, fw, mw, 0);
      end
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL back_to_back cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_mem();
      cyc_t e;
      logic [14:0] obs;
      int n;
      do_reset();
      add(ST_FETCH, 1'b1, rnd_op(), B_MR | B_IR | B_PC, 1'b0);
      add(ST_DECODE, 1'b0, OW'(3), 11'h0, 1'b0);
      add(ST_EXEC, rnd_bit(), rnd_op(), B_AS, 1'b0);
      n = 0;
      while (q.size() != 0) begin
         e = q.pop_front();
         apply(e, obs);
         vectors++;
         if (obs !== {e.st, e.outs, e.ill}) begin
            miscompares++;
            $display("FAIL reset_mid_mem_setup cyc%0d: got %h want %h", n, obs, {e.st, e.outs, e.ill});
         end
         n++;
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      #2;
      obs = observe();
      vectors++;
      if (obs !== {ST_MEM, B_AS | B_MW, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_mem_before: got %h want %h", obs, {ST_MEM, B_AS | B_MW, 1'b0});
      end
      reset = 1'b1;
      #1;
      obs = observe();
      vectors++;
      if (obs !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_mid_mem_async: got %h want %h", obs, 15'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #2;
      obs = observe();
      vectors++;
      if (obs[14:12] !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_mid_mem_idle: got state %0d want %0d", obs[14:12], ST_IDLE);
      end
      @(posedge clk); #3;
      obs = observe();
      vectors++;
      if (obs[14:12] !== ST_FETCH) begin
         miscompares++;
         $display("FAIL reset_mid_mem_fetch: got state %0d want %0d", obs[14:12], ST_FETCH);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode = '0;
      test_reset();
      test_add_sub_jump();
      test_mem_waits();
      test_fetch_timeout();
      test_mem_timeout();
      test_illegal_opcode();
      test_back_to_back();
      test_reset_mid_mem();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
